// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS write-back path.
// Consumed by the write-back FIFO and the register-file port driver.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_req_t;

   function automatic logic [NUM_REGS-1:0] decodeOneHot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] code;
      code       = '0;
      code[addr] = 1'b1;
      return code;
   endfunction

endpackage

// File: rtl/mips_wb_fifo.sv
// Small FIFO of write-back requests; every slot and its valid bit are exposed
// so the forwarding lookup can search writes that have not drained yet.
module mips_wb_fifo import mips_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   pushEn,
   input  wb_req_t                pushReq,
   input  logic                   popEn,
   output wb_req_t                headReq,
   output wb_req_t [DEPTH-1:0]    entries,
   output logic    [DEPTH-1:0]    entryValid,
   output logic    [PTR_W-1:0]    rdPtr,
   output logic    [CNT_W-1:0]    count
);

   wb_req_t [DEPTH-1:0] mem_r;
   logic    [PTR_W-1:0] rdPtr_r;
   logic    [PTR_W-1:0] wrPtr_r;
   logic    [CNT_W-1:0] count_r;
   logic    [PTR_W-1:0] age_s;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage, pointers and occupancy advance together on push/pop
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_r   <= '0;
         rdPtr_r <= '0;
         wrPtr_r <= '0;
         count_r <= '0;
      end else begin
         if (pushEn) begin
            mem_r[wrPtr_r] <= pushReq;
            wrPtr_r        <= nextPtr(wrPtr_r);
         end
         if (popEn) begin
            rdPtr_r <= nextPtr(rdPtr_r);
         end
         case ({pushEn, popEn})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy
   always_comb begin
      age_s      = '0;
      entryValid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_s         = PTR_W'(i) - rdPtr_r;
         entryValid[i] = (CNT_W'(age_s) < count_r);
      end
   end

   assign headReq = mem_r[rdPtr_r];
   assign entries = mem_r;
   assign rdPtr   = rdPtr_r;
   assign count   = count_r;

endmodule

// File: rtl/mips_wb_writer.sv
// Register-file write port driver: buffers write-back requests, drives one
// write per cycle and forwards pending data to two operand-fetch lookups.
module mips_wb_writer import mips_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_addr,
   input  logic [31:0]       in_data,
   input  logic              hold,
   output logic [31:0]       WriteCode,
   output logic              RegWrite,
   output logic [31:0]       RegData,
   input  logic [4:0]        SelA,
   input  logic [4:0]        SelB,
   output logic              HitA,
   output logic              HitB,
   output logic [31:0]       FwdA,
   output logic [31:0]       FwdB,
   output logic [CNT_W-1:0]  Pending
);

   typedef struct packed {
      logic        hit;
      logic [31:0] data;
   } fwd_t;

   logic                pushEn_s;
   logic                popEn_s;
   wb_req_t             headReq_s;
   wb_req_t [DEPTH-1:0] entries_s;
   logic    [DEPTH-1:0] entryValid_s;
   logic    [PTR_W-1:0] rdPtr_s;
   logic    [CNT_W-1:0] count_s;
   logic    [4:0]       regAddr_r;
   fwd_t                fwdA_s;
   fwd_t                fwdB_s;

   // Walk candidates oldest to newest so the youngest match overrides
   function automatic fwd_t lookup(
      input logic [4:0]          sel,
      input logic                outValid,
      input logic [4:0]          outAddr,
      input logic [31:0]         outData,
      input wb_req_t [DEPTH-1:0] ents,
      input logic [DEPTH-1:0]    vld,
      input logic [PTR_W-1:0]    rd
   );
      fwd_t             res;
      logic [PTR_W-1:0] idx;
      res = '0;
      if (outValid && (outAddr == sel)) begin
         res = {1'b1, outData};
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd + PTR_W'(k);
         if (vld[idx] && (ents[idx].addr == sel)) begin
            res = {1'b1, ents[idx].data};
         end
      end
      if (sel == 5'd0) begin
         res = '0;
      end
      return res;
   endfunction

   mips_wb_fifo #(.DEPTH(DEPTH)) uFifo (
      .clock      (clock),
      .reset      (reset),
      .pushEn     (pushEn_s),
      .pushReq    ({in_addr, in_data}),
      .popEn      (popEn_s),
      .headReq    (headReq_s),
      .entries    (entries_s),
      .entryValid (entryValid_s),
      .rdPtr      (rdPtr_s),
      .count      (count_s)
   );

   // Handshake and drain control; writes to $0 complete but are never stored
   always_comb begin
      in_ready = (count_s < CNT_W'(DEPTH));
      pushEn_s = in_valid && in_ready && (in_addr != 5'd0);
      popEn_s  = (count_s != '0) && !hold;
   end

   // Output registers feeding the register-file write port
   always_ff @(posedge clock) begin
      if (reset) begin
         RegWrite  <= 1'b0;
         WriteCode <= 32'h0000_0000;
         RegData   <= 32'h0000_0000;
         regAddr_r <= 5'd0;
      end else if (popEn_s) begin
         RegWrite  <= 1'b1;
         WriteCode <= decodeOneHot(headReq_s.addr);
         RegData   <= headReq_s.data;
         regAddr_r <= headReq_s.addr;
      end else begin
         RegWrite  <= 1'b0;
         WriteCode <= 32'h0000_0000;
      end
   end

   // Forwarding lookups for both operand ports
   always_comb begin
      fwdA_s = lookup(SelA, RegWrite, regAddr_r, RegData, entries_s, entryValid_s, rdPtr_s);
      fwdB_s = lookup(SelB, RegWrite, regAddr_r, RegData, entries_s, entryValid_s, rdPtr_s);
      HitA   = fwdA_s.hit;
      FwdA   = fwdA_s.data;
      HitB   = fwdB_s.hit;
      FwdB   = fwdB_s.data;
   end

   assign Pending = count_s;

endmodule

// File: tb/tb_mips_wb_writer.sv
// Self-checking bench for mips_wb_writer: vector table for handshake and
// forwarding state, scoreboard queue for the register-file write stream.
module tb_mips_wb_writer;
   import mips_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int NV    = 22;

   logic              clock = 1'b0;
   logic              reset;
   logic              inValid;
   logic              inReady;
   logic [4:0]        inAddr;
   logic [31:0]       inData;
   logic              hold;
   logic [31:0]       WriteCode;
   logic              RegWrite;
   logic [31:0]       RegData;
   logic [4:0]        SelA;
   logic [4:0]        SelB;
   logic              HitA;
   logic              HitB;
   logic [31:0]       FwdA;
   logic [31:0]       FwdB;
   logic [CNT_W-1:0]  Pending;

   typedef struct {
      logic        v;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        hold;
      logic [4:0]  selA;
      logic [4:0]  selB;
      logic        expReady;
      int          expPending;
      logic        expHitA;
      logic [31:0] expFwdA;
      logic        expHitB;
      logic [31:0] expFwdB;
   } vec_t;

   vec_t    vecs [NV];
   wb_req_t expQ [$];
   int      nVec = 0;
   int      nMis = 0;

   mips_wb_writer #(.DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_addr   (inAddr),
      .in_data   (inData),
      .hold      (hold),
      .WriteCode (WriteCode),
      .RegWrite  (RegWrite),
      .RegData   (RegData),
      .SelA      (SelA),
      .SelB      (SelB),
      .HitA      (HitA),
      .HitB      (HitB),
      .FwdA      (FwdA),
      .FwdB      (FwdB),
      .Pending   (Pending)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic v, logic [4:0] a, logic [31:0] d, logic h,
                               logic [4:0] sa, logic [4:0] sb, logic rdy, int pend,
                               logic ha, logic [31:0] fa, logic hb, logic [31:0] fb);
      vec_t r;
      r.v = v; r.addr = a; r.data = d; r.hold = h; r.selA = sa; r.selB = sb;
      r.expReady = rdy; r.expPending = pend;
      r.expHitA = ha; r.expFwdA = fa; r.expHitB = hb; r.expFwdB = fb;
      return r;
   endfunction

   // Scoreboard: every observed write must match the oldest expected one
   always @(negedge clock) begin
      wb_req_t e;
      logic [31:0] code;
      if (RegWrite === 1'b1) begin
         if (expQ.size() == 0) begin
            check("unexpectedWrite", 32'(RegWrite), 32'd0);
         end else begin
            e    = expQ.pop_front();
            code = 32'd1 << e.addr;
            check("WriteCode", WriteCode, code);
            check("RegData", RegData, e.data);
         end
      end
   end

   initial begin
      int nWr, first, last, maxPend, readyLow;

      vecs[0]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[1]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
      vecs[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
      vecs[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[5]  = mk(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[6]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[7]  = mk(1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 5'd7, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[8]  = mk(1'b1, 5'd7, 32'h22,       1'b1, 5'd3, 5'd7, 1'b1, 1, 1'b1, 32'h11,       1'b0, 32'h0);
      vecs[9]  = mk(1'b1, 5'd9, 32'h33,       1'b1, 5'd3, 5'd9, 1'b0, 2, 1'b1, 32'h11,       1'b0, 32'h0);
      vecs[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd9, 1'b0, 2, 1'b1, 32'h22,       1'b0, 32'h0);
      vecs[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd7, 1'b1, 1, 1'b1, 32'h11,       1'b1, 32'h22);
      vecs[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd7, 1'b1, 0, 1'b0, 32'h0,        1'b1, 32'h22);
      vecs[13] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd7, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[14] = mk(1'b1, 5'd4, 32'hAAAA,     1'b1, 5'd4, 5'd6, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);
      vecs[15] = mk(1'b1, 5'd4, 32'hBBBB,     1'b1, 5'd4, 5'd6, 1'b1, 1, 1'b1, 32'hAAAA,     1'b0, 32'h0);
      vecs[16] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd6, 1'b0, 2, 1'b1, 32'hBBBB,     1'b0, 32'h0);
      vecs[17] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd6, 1'b0, 2, 1'b1, 32'hBBBB,     1'b0, 32'h0);
      vecs[18] = mk(1'b1, 5'd4, 32'hCCCC,     1'b0, 5'd4, 5'd6, 1'b1, 1, 1'b1, 32'hBBBB,     1'b0, 32'h0);
      vecs[19] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd6, 1'b1, 1, 1'b1, 32'hCCCC,     1'b0, 32'h0);
      vecs[20] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd6, 1'b1, 0, 1'b1, 32'hCCCC,     1'b0, 32'h0);
      vecs[21] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd6, 1'b1, 0, 1'b0, 32'h0,        1'b0, 32'h0);

      reset = 1'b1; inValid = 1'b0; inAddr = 5'd0; inData = 32'h0;
      hold = 1'b0; SelA = 5'd5; SelB = 5'd7;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst.inReady",   32'(inReady),  32'd1);
      check("rst.Pending",   32'(Pending),  32'd0);
      check("rst.RegWrite",  32'(RegWrite), 32'd0);
      check("rst.WriteCode", WriteCode,     32'd0);
      check("rst.RegData",   RegData,       32'd0);
      check("rst.HitA",      32'(HitA),     32'd0);
      check("rst.HitB",      32'(HitB),     32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         inValid = vecs[i].v; inAddr = vecs[i].addr; inData = vecs[i].data;
         hold = vecs[i].hold; SelA = vecs[i].selA; SelB = vecs[i].selB;
         @(negedge clock);
         check($sformatf("v%0d.inReady", i), 32'(inReady), 32'(vecs[i].expReady));
         check($sformatf("v%0d.Pending", i), 32'(Pending), 32'(vecs[i].expPending));
         check($sformatf("v%0d.HitA", i),    32'(HitA),    32'(vecs[i].expHitA));
         check($sformatf("v%0d.FwdA", i),    FwdA,         vecs[i].expFwdA);
         check($sformatf("v%0d.HitB", i),    32'(HitB),    32'(vecs[i].expHitB));
         check($sformatf("v%0d.FwdB", i),    FwdB,         vecs[i].expFwdB);
         if (vecs[i].v && vecs[i].expReady && vecs[i].addr != 5'd0)
            expQ.push_back('{addr: vecs[i].addr, data: vecs[i].data});
         @(posedge clock); #1;
      end

      // Back-to-back stream with simultaneous push and pop
      nWr = 0; first = -1; last = -1; maxPend = 0; readyLow = 0;
      SelA = 5'd0; SelB = 5'd0; hold = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (c < 8) begin
            inValid = 1'b1; inAddr = 5'(c + 1); inData = 32'(c + 1) * 32'h10;
         end else begin
            inValid = 1'b0; inAddr = 5'd0; inData = 32'h0;
         end
         @(negedge clock);
         if (int'(Pending) > maxPend) maxPend = int'(Pending);
         if (c < 8 && inReady !== 1'b1) readyLow++;
         if (RegWrite === 1'b1) begin
            nWr++;
            if (first < 0) first = c;
            last = c;
         end
         if (c < 8) expQ.push_back('{addr: inAddr, data: inData});
         @(posedge clock); #1;
      end
      check("stream.writes",     32'(nWr),              32'd8);
      check("stream.span",       32'(last - first + 1), 32'd8);
      check("stream.maxPending", 32'(maxPend),          32'd1);
      check("stream.readyLow",   32'(readyLow),         32'd0);

      // Reset with two writes buffered under hold
      hold = 1'b1; inValid = 1'b1; inAddr = 5'd10; inData = 32'h55;
      @(posedge clock); #1;
      inAddr = 5'd11; inData = 32'h66;
      @(posedge clock); #1;
      inValid = 1'b0; SelA = 5'd10; SelB = 5'd11;
      @(negedge clock);
      check("midrst.PendingBefore", 32'(Pending), 32'd2);
      check("midrst.HitBefore",     32'(HitB),    32'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; hold = 1'b0;
      @(negedge clock);
      check("midrst.Pending",  32'(Pending),  32'd0);
      check("midrst.RegWrite", 32'(RegWrite), 32'd0);
      check("midrst.HitA",     32'(HitA),     32'd0);
      check("midrst.HitB",     32'(HitB),     32'd0);
      check("midrst.inReady",  32'(inReady),  32'd1);
      repeat (5) @(posedge clock);
      @(negedge clock);
      check("scoreboard.left", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/mips_wb_writer.md
# mips_wb_writer

Write-back port driver for the MIPS register file: accepts write requests (register address + 32-bit data) from the write-back stage over a valid/ready handshake, buffers them in a small FIFO, and drives the register file write port one request per cycle. It generates the one-hot `WriteCode`, the `RegWrite` strobe and `RegData` consumed by the bit-sliced register file. It also exposes a two-port forwarding lookup so operand fetch sees writes that have not yet landed in the register file.

## Interface
- `DEPTH`, 2: FIFO entries, ≥1, power of two.
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; clears FIFO and output registers.
- `in_valid`  in  1  write request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at an edge.
- `in_addr`  in  5  destination register.
- `in_data`  in  32  write data.
- `hold`  in  1  freeze draining (register file busy).
- `WriteCode`  out  32  one-hot register select, registered.
- `RegWrite`  out  1  write strobe, registered.
- `RegData`  out  32  write data, registered.
- `SelA`, `SelB`  in  5  forwarding query addresses.
- `HitA`, `HitB`  out  1  a pending write to `SelA`/`SelB` exists.
- `FwdA`, `FwdB`  out  32  newest pending data for that register; 0 when no hit.
- `Pending`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Reset: FIFO empty, `Pending`=0, `in_ready`=1, `RegWrite`=0, `WriteCode`=0, `RegData`=0, `HitA/HitB`=0.
- `in_ready` = (`Pending` < `DEPTH`); independent of same-cycle pop (no pass-through when full).
- Accepted request with `in_addr`==0: handshake completes, nothing stored ($0 is hard-wired zero).
- Drain: at each edge with `Pending`>0 and `hold`=0, head pops into output registers: `RegWrite`=1, `WriteCode`=1<<addr, `RegData`=data.
- Otherwise at that edge `RegWrite`←0, `WriteCode`←0; `RegData` holds last value.
- Simultaneous push and pop: both happen; `Pending` unchanged; order preserved (FIFO strict).
- Push when full: impossible by handshake; `in_valid` with `in_ready`=0 is ignored, no state change.
- Forwarding (combinational): candidates are the output register (if `RegWrite`=1) and all valid FIFO entries; match on address, newest wins (youngest FIFO entry > older entries > output register). Sel=0 never hits.
- Reset mid-operation: all buffered writes discarded; `RegWrite` low from the cycle after the reset edge.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty from `Pending`.

## Timing
- Accept at edge E0 → entry in FIFO after E0 → earliest pop at E1 → `RegWrite`/`WriteCode`/`RegData` valid in cycle after E1 → register file captures at E2.
- Forwarding hit valid from cycle after E0 until the cycle after E2, when data is in the register file.
- Sustained throughput: one write per cycle with `hold`=0; `Pending` stays ≤1.
- `hold` sampled at the edge: pop suppressed at that edge; `RegWrite` deasserted in following cycle.

## Structure
- Package `mips_pkg`: `REG_ADDR_W`=5, `NUM_REGS`=32, `DATA_W`=32, `typedef struct packed { logic [4:0] addr; logic [31:0] data; } wb_req_t`.
- Sub-module `mips_wb_fifo`: parameterized `wb_req_t` FIFO exposing all entries plus valid bits to the forwarding lookup.
- Top holds output registers, one-hot decode, forwarding priority logic.

## Test plan
- Single write: reset, push (addr 5, 0xDEADBEEF) → after E1 `RegWrite`=1, `WriteCode`=0x00000020, `RegData`=0xDEADBEEF for exactly one cycle; `Pending` back to 0.
- $0 drop: push (0, 0x12345678) → `in_ready`=1, `Pending` stays 0, `RegWrite` never asserts, `SelA`=0 → `HitA`=0.
- Fill under hold: `hold`=1, push (3,0x11),(7,0x22) → `Pending`=2, `in_ready`=0, third request (9,0x33) ignored; release hold → writes to 3 then 7 on consecutive cycles, `WriteCode` 0x8 then 0x80.
- Forwarding priority: `hold`=1, push (4,0xAAAA),(4,0xBBBB); `SelA`=4 → `HitA`=1, `FwdA`=0xBBBB; `SelB`=6 → `HitB`=0, `FwdB`=0.
- Simultaneous push/pop: streaming 8 writes (addr 1..8, data=addr×0x10) back-to-back → 8 consecutive `RegWrite` cycles, same order, `Pending`≤1.
- Reset mid-operation: `Pending`=2 under hold, assert `reset` one cycle → `Pending`=0, `RegWrite`=0, no hits, no stale write after reset.
